// File: rtl/sorter_feeder.sv
// sorter_feeder: collects a serial stream of metric words into a frame of
// 4*(M+1) words and hands it to the sorter four words per cycle. It then holds
// the last group until the sorter reports done.
// Optional feature: define SORTER_FEEDER_PAD_EN so that in_last ends a frame
// early. The unfilled slots are then padded with all-ones, the maximum metric.
module sorter_feeder #(
    parameter int WIDTH     = 16,
    parameter int MAX_WORDS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       M_in,
    input  logic             sorter_done,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] d4,
    output logic             start,
    output logic [1:0]       M,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       g_q, g_d;
    logic [1:0]       m_q, m_d;
    logic             start_q, start_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] d_q [4];
    logic [WIDTH-1:0] d_d [4];
    logic [WIDTH-1:0] buf_q [MAX_WORDS];
    logic [WIDTH-1:0] buf_d [MAX_WORDS];

    logic             xfer;
    logic [1:0]       eff_m;
    logic [3:0]       last_idx;
    logic             early_end;
    logic             frame_end;
    logic [1:0]       g_nxt;

    // Transfer qualifiers. The first word of a frame uses M_in directly because m_q is not yet latched.
    always_comb begin
        xfer      = in_valid & in_ready_q;
        eff_m     = (state_q == S_IDLE) ? M_in : m_q;
        last_idx  = {eff_m, 2'b11};
        g_nxt     = g_q + 2'd1;
`ifdef SORTER_FEEDER_PAD_EN
        early_end = in_last;
`else
        early_end = 1'b0;
`endif
        frame_end = xfer && ((cnt_q == last_idx) || early_end);
    end

`ifndef SORTER_FEEDER_PAD_EN
    logic unused_last;
    assign unused_last = in_last;
`endif

    // Per-slot buffer write. An early end pads the slots above the current word up to the end of the frame.
    generate
        for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_slot
            always_comb begin
                buf_d[gi] = buf_q[gi];
                if (xfer && (cnt_q == 4'(gi))) begin
                    buf_d[gi] = in_data;
                end else if (xfer && early_end && (4'(gi) > cnt_q) && (4'(gi) <= last_idx)) begin
                    buf_d[gi] = {WIDTH{1'b1}};
                end
            end

            // Slot storage: the contents are deliberately not cleared by reset.
            always_ff @(posedge clk) begin
                buf_q[gi] <= buf_d[gi];
            end
        end
    endgenerate

    // State register and all control/output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            g_q        <= '0;
            m_q        <= '0;
            start_q    <= 1'b0;
            in_ready_q <= 1'b0;
            for (int k = 0; k < 4; k++) d_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            g_q        <= g_d;
            m_q        <= m_d;
            start_q    <= start_d;
            in_ready_q <= in_ready_d;
            for (int k = 0; k < 4; k++) d_q[k] <= d_d[k];
        end
    end

    // Next-state logic. Group 0 is taken from the post-write view so that it appears the cycle after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        m_d     = m_q;
        start_d = 1'b0;
        for (int k = 0; k < 4; k++) d_d[k] = d_q[k];
        case (state_q)
            S_IDLE, S_FILL: begin
                if (xfer) begin
                    if (state_q == S_IDLE) m_d = M_in;
                    if (frame_end) begin
                        state_d = S_ISSUE;
                        cnt_d   = '0;
                        g_d     = '0;
                        start_d = 1'b1;
                        for (int k = 0; k < 4; k++) d_d[k] = buf_d[k];
                    end else begin
                        state_d = S_FILL;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (g_q == m_q) begin
                    state_d = S_WAIT;
                end else begin
                    g_d = g_nxt;
                    for (int k = 0; k < 4; k++) d_d[k] = buf_q[{g_nxt, k[1:0]}];
                end
            end
            S_WAIT: begin
                if (sorter_done) begin
                    state_d = S_IDLE;
                    g_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_FILL);
    end

    // Output decode.
    always_comb begin
        busy     = (state_q != S_IDLE);
        in_ready = in_ready_q;
        start    = start_q;
        M        = m_q;
        d1       = d_q[0];
        d2       = d_q[1];
        d3       = d_q[2];
        d4       = d_q[3];
    end

endmodule

// File: tb/tb_sorter_feeder.sv
// Testbench for sorter_feeder: directed and randomized frames checked against a
// queue-based frame model. This model pads on in_last only when SORTER_FEEDER_PAD_EN is defined.
module tb_sorter_feeder;
    localparam int W = 16;

`ifdef SORTER_FEEDER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         sorter_done = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [1:0]   M_in = 2'd0;
    logic         in_ready, start, busy;
    logic [W-1:0] d1, d2, d3, d4;
    logic [1:0]   M;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] stim [16];
    logic [W-1:0] exp_q [$];

    sorter_feeder #(.WIDTH(W), .MAX_WORDS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .M_in(M_in), .sorter_done(sorter_done),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .start(start), .M(M), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Offer one word at the current negedge and return at the negedge after it was accepted.
    task automatic send_word(input logic [W-1:0] w, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            chk("rdy_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Feed stim[] until the model frame holds 4*(m+1) words.
    task automatic fill(input logic [1:0] m, input int last_idx, input bit gaps, input bit mchange);
        int n = 4 * (int'(m) + 1);
        int i = 0;
        exp_q.delete();
        M_in = m;
        while (exp_q.size() < n && i < 16) begin
            send_word(stim[i], i == last_idx);
            exp_q.push_back(stim[i]);
            if (PAD && i == last_idx)
                while (exp_q.size() < n) exp_q.push_back({W{1'b1}});
            if (!PAD && i == last_idx && exp_q.size() < n) begin
                repeat (2) begin
                    chk("nopad_wait_start", 32'(start), 32'd0);
                    chk("nopad_wait_rdy", 32'(in_ready), 32'd1);
                    @(negedge clk);
                end
            end
            if (mchange && i == 0) M_in = 2'(int'(m) + 1 + int'($urandom_range(0, 2)));
            if (gaps && exp_q.size() < n) begin
                repeat ($urandom_range(1, 3)) begin
                    chk("gap_busy", 32'(busy), 32'd1);
                    chk("gap_rdy", 32'(in_ready), 32'd1);
                    @(negedge clk);
                end
            end
            i++;
        end
    endtask

    // Called at the negedge after the last transfer: check every group, then the hold in WAIT.
    task automatic issue_check(input logic [1:0] m, input int hold);
        int ng = int'(m) + 1;
        int b;
        for (int k = 0; k < ng; k++) begin
            if (k > 0) @(negedge clk);
            sorter_done = 1'b0;
            chk("start", 32'(start), (k == 0) ? 32'd1 : 32'd0);
            chk("grp_d1", 32'(d1), 32'(exp_q[4*k]));
            chk("grp_d2", 32'(d2), 32'(exp_q[4*k+1]));
            chk("grp_d3", 32'(d3), 32'(exp_q[4*k+2]));
            chk("grp_d4", 32'(d4), 32'(exp_q[4*k+3]));
            chk("M", 32'(M), 32'(m));
            chk("issue_busy", 32'(busy), 32'd1);
            chk("issue_rdy", 32'(in_ready), 32'd0);
            sorter_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        sorter_done = 1'b0;
        b = 4 * (ng - 1);
        repeat (hold) begin
            chk("hold_d1", 32'(d1), 32'(exp_q[b]));
            chk("hold_d4", 32'(d4), 32'(exp_q[b+3]));
            chk("hold_start", 32'(start), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_rdy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic finish_frame();
        sorter_done = 1'b1;
        chk("wait_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        sorter_done = 1'b0;
        chk("done_rdy", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0] rm;

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_d1", 32'(d1), 32'd0);
        chk("rst_M", 32'(M), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'(in_ready), 32'd1);

        // QPSK frame 5,3,9,1
        stim[0] = 16'd5; stim[1] = 16'd3; stim[2] = 16'd9; stim[3] = 16'd1;
        fill(2'd0, -1, 1'b0, 1'b0);
        issue_check(2'd0, 2);
        finish_frame();

        // QAM256 frame 0..15
        for (int i = 0; i < 16; i++) stim[i] = 16'(i);
        fill(2'd3, -1, 1'b0, 1'b0);
        issue_check(2'd3, 3);

        // Done and a new word in the same cycle: the word waits one cycle
        for (int i = 0; i < 16; i++) stim[i] = 16'($urandom);
        sorter_done = 1'b1;
        in_valid    = 1'b1;
        in_data     = stim[0];
        M_in        = 2'd1;
        chk("b2b_rdy_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        sorter_done = 1'b0;
        chk("b2b_rdy_high", 32'(in_ready), 32'd1);
        chk("b2b_busy", 32'(busy), 32'd0);

        // QAM16 with gaps and M_in changing mid-frame
        fill(2'd1, -1, 1'b1, 1'b1);
        issue_check(2'd1, 1);
        finish_frame();

        // Done during FILL is ignored, then reset during ISSUE of a QAM64 frame
        for (int i = 0; i < 16; i++) stim[i] = 16'($urandom);
        M_in = 2'd2;
        for (int i = 0; i < 5; i++) send_word(stim[i], 1'b0);
        sorter_done = 1'b1;
        @(negedge clk);
        sorter_done = 1'b0;
        chk("fill_done_busy", 32'(busy), 32'd1);
        chk("fill_done_rdy", 32'(in_ready), 32'd1);
        for (int i = 5; i < 12; i++) send_word(stim[i], 1'b0);
        chk("pre_rst_start", 32'(start), 32'd1);
        chk("pre_rst_d1", 32'(d1), 32'(stim[0]));
        #2 rst = 1'b0;
        #1;
        chk("arst_start", 32'(start), 32'd0);
        chk("arst_d1", 32'(d1), 32'd0);
        chk("arst_d4", 32'(d4), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd0);
        chk("arst_M", 32'(M), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rerst_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 16; i++) stim[i] = 16'($urandom);
        fill(2'd0, -1, 1'b0, 1'b0);
        issue_check(2'd0, 1);
        finish_frame();

        // in_last on the 6th word of a QAM64 frame
        for (int i = 0; i < 16; i++) stim[i] = 16'($urandom_range(0, 16'hFFFE));
        fill(2'd2, 5, 1'b0, 1'b0);
        issue_check(2'd2, 1);
        finish_frame();

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 16; i++) stim[i] = 16'($urandom);
            rm = 2'($urandom_range(0, 3));
            fill(rm, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            issue_check(rm, int'($urandom_range(0, 3)));
            finish_frame();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
